// File: rtl/pdl_buffer_p.sv
// PDL buffer: stack pointer with push/pop, indexed access, occupancy count and sticky ovf/unf flags.
// Latency: reads return on pdlo one clock after the request; ptr, level and the flags update on the same edge.
// Backpressure: none. One command is accepted every cycle; ovf/unf report misuse instead of stalling.
//
// Ports: clk/reset (async, active-high); l write data; push/pop/prp/pwp/ptr_ld commands;
//        pdla index address; ptr_in pointer load value; ptr current pointer; pdlo/pdlo_vld read data;
//        level occupancy 0..2**AWIDTH; ovf/unf sticky flags; flag_clr clears the flags.
// Optional: define PDL_PARITY_EN to store even parity per word and add the perr output.
module pdl_buffer_p #(
    parameter int WIDTH  = 32,
    parameter int AWIDTH = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  l,
    input  logic              push,
    input  logic              pop,
    input  logic              prp,
    input  logic              pwp,
    input  logic [AWIDTH-1:0] pdla,
    input  logic              ptr_ld,
    input  logic [AWIDTH-1:0] ptr_in,
    output logic [AWIDTH-1:0] ptr,
    output logic [WIDTH-1:0]  pdlo,
    output logic              pdlo_vld,
    output logic [AWIDTH:0]   level,
    output logic              ovf,
    output logic              unf,
    input  logic              flag_clr
`ifdef PDL_PARITY_EN
    ,
    output logic              perr
`endif
);

`ifdef PDL_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif
    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] FULL = (AWIDTH + 1)'(DEPTH);

    logic [MW-1:0] mem [DEPTH];

    logic              we;
    logic [AWIDTH-1:0] waddr;
    logic              re;
    logic [AWIDTH-1:0] raddr;
    logic              fwd;
    logic [AWIDTH-1:0] ptr_nxt;
    logic [AWIDTH:0]   level_nxt;
    logic              ovf_set;
    logic              unf_set;
    logic [MW-1:0]     wword;
    logic [MW-1:0]     rword;

    // Command decode; priority ptr_ld > push&pop > push > pop > prp/pwp.
    always_comb begin
        we        = 1'b0;
        waddr     = ptr;
        re        = 1'b0;
        raddr     = ptr;
        fwd       = 1'b0;
        ptr_nxt   = ptr;
        level_nxt = level;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (ptr_ld) begin
            ptr_nxt = ptr_in;
        end else if (push && pop) begin
            // Replace top: the RAM read sees the old word because the write lands on the same edge.
            we = 1'b1;
            re = 1'b1;
        end else if (push) begin
            we      = 1'b1;
            waddr   = ptr + AWIDTH'(1);
            ptr_nxt = ptr + AWIDTH'(1);
            if (level == FULL) ovf_set = 1'b1;
            else               level_nxt = level + (AWIDTH + 1)'(1);
        end else if (pop) begin
            re      = 1'b1;
            ptr_nxt = ptr - AWIDTH'(1);
            if (level == '0) unf_set = 1'b1;
            else             level_nxt = level - (AWIDTH + 1)'(1);
        end else begin
            re    = prp;
            raddr = pdla;
            we    = pwp;
            waddr = pdla;
            // Indexed read+write of one word is write-through: return l, not the stale word.
            fwd   = prp && pwp;
        end
    end

`ifdef PDL_PARITY_EN
    assign wword = {^l, l};   // even parity over the stored word
`else
    assign wword = l;
`endif

    // RAM storage is never reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wword;
    end

    assign rword = mem[raddr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pdlo     <= '0;
            pdlo_vld <= 1'b0;
`ifdef PDL_PARITY_EN
            perr     <= 1'b0;
`endif
        end else begin
            pdlo_vld <= re;
            if (re) pdlo <= fwd ? l : rword[WIDTH-1:0];
`ifdef PDL_PARITY_EN
            perr     <= re && !fwd && (^rword);
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            level <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            ptr   <= ptr_nxt;
            level <= level_nxt;
            // A same-cycle set takes precedence over flag_clr.
            ovf   <= ovf_set | (ovf & ~flag_clr);
            unf   <= unf_set | (unf & ~flag_clr);
        end
    end

endmodule
